// File: rtl/mem_xbar.sv
// mem_xbar: NM-master by NS-slave memory crossbar with base/mask decode, per-slave
// round-robin arbitration, decode-miss errors and a per-slave busy timeout.
module mem_xbar #(
  parameter int NM = 4,
  parameter int NS = 6,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter logic [NS*AW-1:0] SLV_BASE = '0,
  parameter logic [NS*AW-1:0] SLV_MASK = '0,
  parameter int TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NM-1:0]     m_valid,
  input  logic [NM*AW-1:0]  m_addr,
  input  logic [NM*DW-1:0]  m_wdata,
  input  logic [NM*DW/8-1:0] m_wstrb,
  output logic [NM*DW-1:0]  m_rdata,
  output logic [NM-1:0]     m_ready,
  output logic [NM-1:0]     m_error,
  output logic [NS-1:0]     s_valid,
  output logic [NS*AW-1:0]  s_addr,
  output logic [NS*DW-1:0]  s_wdata,
  output logic [NS*DW/8-1:0] s_wstrb,
  input  logic [NS*DW-1:0]  s_rdata,
  input  logic [NS-1:0]     s_ready,
  input  logic [NS-1:0]     s_error
);
  localparam int WW = DW/8;
  localparam int IW = NM > 1 ? $clog2(NM) : 1;
  localparam int SW = NS > 1 ? $clog2(NS) : 1;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT+1) : 1;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT > 0 ? TIMEOUT-1 : 0);
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  logic [NM-1:0] pending, miss, d_hit;
  logic [AW-1:0] h_addr [NM];
  logic [DW-1:0] h_wdata [NM];
  logic [WW-1:0] h_wstrb [NM];
  logic [SW-1:0] h_sidx [NM];
  logic [SW-1:0] d_sidx [NM];
  state_t state [NS];
  state_t state_n [NS];
  logic [IW-1:0] owner [NS];
  logic [IW-1:0] rr [NS];
  logic [IW-1:0] grant [NS];
  logic [CW-1:0] cnt [NS];
  logic [NM-1:0] req [NS];
  // Descending scan so the lowest-index matching window wins
  always_comb begin
    for (int m = 0; m < NM; m++) begin
      d_hit[m] = 1'b0;
      d_sidx[m] = '0;
      for (int s = NS-1; s >= 0; s--)
        if ((m_addr[m*AW +: AW] & SLV_MASK[s*AW +: AW]) == SLV_BASE[s*AW +: AW]) begin
          d_hit[m] = 1'b1;
          d_sidx[m] = SW'(s);
        end
    end
  end
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      req[s] = '0;
      grant[s] = '0;
      for (int m = 0; m < NM; m++)
        req[s][m] = pending[m] & ~miss[m] & (h_sidx[m] == SW'(s));
      for (int i = NM-1; i >= 0; i--)
        if (req[s][(int'(rr[s]) + i) % NM]) grant[s] = IW'((int'(rr[s]) + i) % NM);
      state_n[s] = state[s] == IDLE ? (|req[s] ? BUSY : IDLE) :
                   state[s] == BUSY ? (s_ready[s] ? IDLE :
                                       (TIMEOUT > 0 && cnt[s] == TLAST) ? DRAIN : BUSY) :
                   IDLE;
    end
  end
  // DRAIN is the cycle that carries the timeout error back to the owner
  always_comb begin
    m_ready = pending & miss;
    m_error = pending & miss;
    m_rdata = '0;
    for (int s = 0; s < NS; s++)
      for (int m = 0; m < NM; m++)
        if (owner[s] == IW'(m) && ((state[s] == BUSY && s_ready[s]) || state[s] == DRAIN)) begin
          m_ready[m] = 1'b1;
          m_error[m] = state[s] == DRAIN ? 1'b1 : s_error[s];
          m_rdata[m*DW +: DW] = state[s] == DRAIN ? '0 : s_rdata[s*DW +: DW];
        end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NS; s++) state[s] <= IDLE;
    end else begin
      for (int s = 0; s < NS; s++) state[s] <= state_n[s];
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
      miss <= '0;
      s_valid <= '0;
      s_addr <= '0;
      s_wdata <= '0;
      s_wstrb <= '0;
      for (int m = 0; m < NM; m++) begin
        h_addr[m] <= '0;
        h_wdata[m] <= '0;
        h_wstrb[m] <= '0;
        h_sidx[m] <= '0;
      end
      for (int s = 0; s < NS; s++) begin
        owner[s] <= '0;
        rr[s] <= '0;
        cnt[s] <= '0;
      end
    end else begin
      for (int m = 0; m < NM; m++)
        if (m_ready[m]) pending[m] <= 1'b0;
        else if (m_valid[m] && !pending[m]) begin
          pending[m] <= 1'b1;
          miss[m] <= ~d_hit[m];
          h_addr[m] <= m_addr[m*AW +: AW];
          h_wdata[m] <= m_wdata[m*DW +: DW];
          h_wstrb[m] <= m_wstrb[m*WW +: WW];
          h_sidx[m] <= d_sidx[m];
        end
      s_valid <= '0;
      for (int s = 0; s < NS; s++)
        if (state[s] == IDLE && |req[s]) begin
          s_valid[s] <= 1'b1;
          s_addr[s*AW +: AW] <= h_addr[grant[s]] - SLV_BASE[s*AW +: AW];
          s_wdata[s*DW +: DW] <= h_wdata[grant[s]];
          s_wstrb[s*WW +: WW] <= h_wstrb[grant[s]];
          owner[s] <= grant[s];
          rr[s] <= IW'((int'(grant[s]) + 1) % NM);
          cnt[s] <= '0;
        end else if (state[s] == BUSY) cnt[s] <= cnt[s] + 1'b1;
    end
  end
  a_single_outstanding: assert property (@(posedge clock) disable iff (reset) !(|(m_valid & pending)));
endmodule

// File: doc/mem_xbar.md
Name: mem_xbar

Overview:
- Parametrised NM-master by NS-slave memory crossbar. It is the successor of the fixed two-core bus/arbiter pair.
- Each master request is decoded against per-slave base/mask windows and rebased to a slave-local address.
- Each slave has a round-robin arbiter, so different masters can reach different slaves concurrently.
- Unmapped addresses get an error response.
- A hung slave is cut off by a per-slave timeout.
- Sits between the core-side instruction/data ports and the TIM/ROM/RAM/SPI/CLINT/UART targets.

Parameters:
- NM, 4, number of masters (1..8)
- NS, 6, number of slaves (1..16)
- AW, 32, address width
- DW, 32, data width; strobe width is DW/8
- SLV_BASE, {NS{32'h0}}, packed NS*AW base addresses; slave i occupies bits [i*AW +: AW]
- SLV_MASK, {NS{32'h0}}, packed NS*AW masks; hit when (addr & mask) == base
- TIMEOUT, 1024, cycles a slave may stay busy before an error is returned; 0 disables the timeout

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m_valid  in  NM  request pulse, one per master
- m_addr  in  NM*AW  request address
- m_wdata  in  NM*DW  write data
- m_wstrb  in  NM*DW/8  byte strobes; all zero means read
- m_rdata  out  NM*DW  response data
- m_ready  out  NM  response pulse
- m_error  out  NM  response error, qualified by m_ready
- s_valid  out  NS  slave request pulse
- s_addr  out  NS*AW  rebased address (addr - base)
- s_wdata  out  NS*DW  write data
- s_wstrb  out  NS*DW/8  byte strobes
- s_rdata  in  NS*DW  slave read data
- s_ready  in  NS  slave response pulse
- s_error  in  NS  slave error

Behaviour:
- Reset (asynchronous, reset=1): all hold registers empty; every slave state IDLE; round-robin pointers 0; all m_*/s_* outputs 0.
- Master protocol: m_valid is a one-cycle pulse. A master has at most one outstanding request. A pulse from a master whose hold register is full is ignored; this is a protocol violation, and the assertion m_valid & pending must never fire.
- Capture: on an m_valid pulse the request and its decoded slave index go into that master's hold register, pending=1.
- Decode: lowest-index matching slave wins on overlapping windows. No match means a decode miss.
- Decode miss: m_ready=1, m_error=1, m_rdata=0 exactly one cycle after the m_valid pulse. Pending clears; no slave is touched.
- Per-slave FSM:
  - IDLE: if any pending master targets this slave, grant the first requester at or after rr_ptr, scanning cyclically. That cycle the FSM registers s_valid=1 for one cycle with the rebased address, wdata and wstrb; owner <= grant; rr_ptr <= grant+1 mod NM; counter <= 0; next state BUSY.
  - BUSY: on s_ready, forward combinationally in the same cycle to the owner: m_ready=1, m_rdata=s_rdata, m_error=s_error. The owner's pending clears and the FSM returns to IDLE. Otherwise the counter increments.
  - BUSY timeout: if TIMEOUT>0 and the counter reaches TIMEOUT-1 without s_ready, return m_ready=1, m_error=1, m_rdata=0 to the owner and go to DRAIN.
  - DRAIN: new grants to this slave are blocked. A late s_ready is discarded and never forwarded, and the FSM goes to IDLE.
- Minimum latency, master pulse to s_valid: 1 cycle. The pulse is captured at edge T and the grant is issued at edge T+1.
- Zero-wait slave (s_ready in the cycle after s_valid): total latency 2 cycles.
- Concurrency: different slaves serve different masters in the same cycle. Each master receives at most one m_ready per cycle, guaranteed by the single-outstanding rule.
- Stray input: s_ready in IDLE, or from a non-owner, is ignored.
- Simultaneous events: a slave completing and a new grant to the same slave in one cycle is not allowed. IDLE is always entered for at least one cycle between transactions.
- Reset mid-transaction: all pending and owner state is lost and outputs go to 0 immediately. Slaves must also be reset.
- Width rules:
  - s_addr is computed modulo 2^AW.
  - The timeout counter width is clog2(TIMEOUT+1).
  - Grant and owner indices are clog2(NM) bits wide, with a minimum of 1 bit.

Test Plan:
- Single read: master 0 reads 0x8000_0004 with RAM at base 0x8000_0000 / mask 0xFFF0_0000. Required: s_valid on RAM one cycle later with s_addr=0x4. Slave returns s_rdata=0xDEADBEEF after 3 cycles; m_ready[0]=1 and m_rdata=0xDEADBEEF in that same cycle.
- Contention: masters 0..3 all pulse to the same slave in one cycle, slave latency 1. Required: grant order 0,1,2,3. A second burst after the pointer reaches 1 is served in order 1,2,3,0.
- Concurrency: master 0 targets slave 0 and master 1 targets slave 2 in the same cycle. Required: both s_valid assert in the same cycle and both m_ready return independently.
- Decode miss: address 0x0000_0000 with no matching window. Required: m_ready=1, m_error=1, m_rdata=0 exactly one cycle later, and no s_valid.
- Timeout: TIMEOUT=8 with a slave that never responds. Required: m_error pulse 8 cycles after s_valid. A late s_ready at cycle 20 is not forwarded, and the next request to that slave is then granted normally.
- Async reset: assert reset during BUSY. Required: all outputs go to 0 without a clock edge, and after release the first request completes normally.
